// File: rtl/timer_pkg.sv
// Shared constants for the timer block: widths, FSM encoding and register map.
package timer_pkg;

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned HALF_W = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [7:0] ADDR_TDR0  = 8'h04;
  localparam logic [7:0] ADDR_TDR1  = 8'h08;
  localparam logic [7:0] ADDR_TCMP0 = 8'h0C;
  localparam logic [7:0] ADDR_TCMP1 = 8'h10;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: divides RUN cycles by div_val+1 and emits a one-cycle count tick.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic             i_div_en,
  input  logic [DIV_W-1:0] i_div_val,
  output logic             o_tick_c
);

  logic [DIV_W-1:0] r_int_cnt;
  logic [DIV_W-1:0] r_div_val_q;
  logic             r_div_en_q;
  logic             w_cfg_chg;

  // Any reprogramming of the divider restarts the phase from zero.
  assign w_cfg_chg = (i_div_val != r_div_val_q) || (i_div_en != r_div_en_q);
  assign o_tick_c  = i_run && (!i_div_en || (r_int_cnt == i_div_val));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_cnt   <= '0;
      r_div_val_q <= '0;
      r_div_en_q  <= 1'b0;
    end else begin
      r_div_val_q <= i_div_val;
      r_div_en_q  <= i_div_en;
      if (i_clr || w_cfg_chg || !i_div_en) begin
        r_int_cnt <= '0;
      end else if (i_run) begin
        r_int_cnt <= o_tick_c ? '0 : r_int_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_cnt_cmp.sv
// 64-bit timer counter with run/halt control, software preload and a sticky
// compare-match status driving the timer interrupt.
module timer_cnt_cmp
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              timer_en,
  input  logic              div_en,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              halt_req,
  input  logic              dbg_mode,
  input  logic              tdr0_wr,
  input  logic              tdr1_wr,
  input  logic [HALF_W-1:0] wr_data,
  input  logic [HALF_W-1:0] tcmp0,
  input  logic [HALF_W-1:0] tcmp1,
  input  logic              int_en,
  input  logic              int_st_clr,
  output logic [HALF_W-1:0] cnt_lo,
  output logic [HALF_W-1:0] cnt_hi,
  output logic              halt_ack,
  output logic              int_st,
  output logic              tim_int
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_en_q;
  logic             r_halt_ack;
  logic             r_int_st;
  logic             w_run;
  logic             w_fall;
  logic             w_tick;
  logic             w_match;
  logic             w_halt_cond;

  assign w_run       = (r_state == ST_RUN);
  assign w_fall      = r_en_q && !timer_en;
  assign w_match     = (r_cnt == {tcmp1, tcmp0});
  assign w_halt_cond = halt_req && dbg_mode;

  timer_prescaler u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_clr     (w_fall),
    .i_div_en  (div_en),
    .i_div_val (div_val),
    .o_tick_c  (w_tick)
  );

  // State register; halt_ack tracks the HALT state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_halt_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_halt_ack <= (w_state_nxt == ST_HALT);
    end
  end

  // Next-state logic; dropping timer_en overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (timer_en) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_halt_cond) w_state_nxt = ST_HALT;
      ST_HALT: if (!w_halt_cond) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!timer_en) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Counter next value: software writes override their half of clear/increment.
  always_comb begin
    w_cnt_base = r_cnt;
    if (w_fall) begin
      w_cnt_base = '0;
    end else if (w_tick) begin
      w_cnt_base = r_cnt + CNT_W'(1);
    end
    w_cnt_nxt = w_cnt_base;
    if (tdr0_wr) begin
      w_cnt_nxt[HALF_W-1:0] = wr_data;
    end
    if (tdr1_wr) begin
      w_cnt_nxt[CNT_W-1:HALF_W] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_en_q   <= 1'b0;
      r_int_st <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_en_q   <= timer_en;
      r_int_st <= w_match || (r_int_st && !int_st_clr);
    end
  end

  assign cnt_lo   = r_cnt[HALF_W-1:0];
  assign cnt_hi   = r_cnt[CNT_W-1:HALF_W];
  assign halt_ack = r_halt_ack;
  assign int_st   = r_int_st;
  assign tim_int  = r_int_st && int_en;

endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Self-checking bench for timer_cnt_cmp: directed scenarios followed by random
// traffic, all compared against a behavioural model of the timer.
module tb_timer_cnt_cmp;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk;
  logic        rst;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        dbg_mode;
  logic        tdr0_wr;
  logic        tdr1_wr;
  logic [31:0] wr_data;
  logic [31:0] tcmp0;
  logic [31:0] tcmp1;
  logic        int_en;
  logic        int_st_clr;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;
  logic        halt_ack;
  logic        int_st;
  logic        tim_int;

  int n_chk;
  int n_fail;

  logic [63:0] m_cnt;
  int          m_phase;
  int          m_mode;
  bit          m_st;
  bit          m_en_q;

  timer_cnt_cmp dut (
    .clk        (clk),
    .rst        (rst),
    .timer_en   (timer_en),
    .div_en     (div_en),
    .div_val    (div_val),
    .halt_req   (halt_req),
    .dbg_mode   (dbg_mode),
    .tdr0_wr    (tdr0_wr),
    .tdr1_wr    (tdr1_wr),
    .wr_data    (wr_data),
    .tcmp0      (tcmp0),
    .tcmp1      (tcmp1),
    .int_en     (int_en),
    .int_st_clr (int_st_clr),
    .cnt_lo     (cnt_lo),
    .cnt_hi     (cnt_hi),
    .halt_ack   (halt_ack),
    .int_st     (int_st),
    .tim_int    (tim_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: predict from the inputs held across the edge, then compare.
  task automatic cyc();
    logic [63:0] nxt;
    int          nmode;
    int          nphase;
    bit          tick;
    bit          match;
    bit          fall;
    bit          nst;
    tick  = (m_mode == M_RUN) &&
            (!div_en || ((m_phase % (int'(div_val) + 1)) == int'(div_val)));
    match = (m_cnt == {tcmp1, tcmp0});
    fall  = m_en_q && !timer_en;
    nxt   = fall ? 64'd0 : (tick ? m_cnt + 64'd1 : m_cnt);
    if (tdr0_wr) nxt[31:0] = wr_data;
    if (tdr1_wr) nxt[63:32] = wr_data;
    if (!timer_en) nmode = M_IDLE;
    else if (halt_req && dbg_mode && m_mode != M_IDLE) nmode = M_HALT;
    else nmode = M_RUN;
    if (fall || !div_en) nphase = 0;
    else if (m_mode == M_RUN) nphase = m_phase + 1;
    else nphase = m_phase;
    nst = match || (m_st && !int_st_clr);
    if (rst) begin
      nxt = 64'd0; nmode = M_IDLE; nphase = 0; nst = 1'b0;
    end
    @(posedge clk);
    #1;
    m_cnt   = nxt;
    m_mode  = nmode;
    m_phase = nphase;
    m_st    = nst;
    m_en_q  = rst ? 1'b0 : timer_en;
    check("cnt_lo", 64'(cnt_lo), 64'(m_cnt[31:0]));
    check("cnt_hi", 64'(cnt_hi), 64'(m_cnt[63:32]));
    check("halt_ack", 64'(halt_ack), 64'(m_mode == M_HALT));
    check("int_st", 64'(int_st), 64'(m_st));
    check("tim_int", 64'(tim_int), 64'(m_st && int_en));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Disable, reprogram the divider while idle, re-enable and enter RUN.
  task automatic restart(input logic de, input logic [3:0] dv);
    timer_en = 1'b0; div_en = de; div_val = dv;
    run(2);
    timer_en = 1'b1;
    run(1);
  endtask

  task automatic run_to(input logic [63:0] target);
    for (int i = 0; i < 200 && m_cnt != target; i++) cyc();
  endtask

  initial begin
    logic [63:0] hold;
    n_chk = 0; n_fail = 0;
    m_cnt = '0; m_phase = 0; m_mode = M_IDLE; m_st = 1'b0; m_en_q = 1'b0;
    rst = 1'b1; timer_en = 1'b0; div_en = 1'b0; div_val = '0;
    halt_req = 1'b0; dbg_mode = 1'b0; tdr0_wr = 1'b0; tdr1_wr = 1'b0;
    wr_data = '0; tcmp0 = '1; tcmp1 = '1; int_en = 1'b0; int_st_clr = 1'b0;
    run(2);
    check("rst_lo", 64'(cnt_lo), 64'd0);
    check("rst_ack", 64'(halt_ack), 64'd0);
    check("rst_int", 64'(tim_int), 64'd0);
    rst = 1'b0;

    // Basic count: one clock to enter RUN, then a tick every cycle
    timer_en = 1'b1;
    run(10);
    check("basic_lo", 64'(cnt_lo), 64'd9);
    check("basic_hi", 64'(cnt_hi), 64'd0);
    check("basic_st", 64'(int_st), 64'd0);

    // Prescaler ratios 4, 1 and 9
    restart(1'b1, 4'd3); run(40);
    check("div4", 64'(cnt_lo), 64'd10);
    restart(1'b1, 4'd0); run(40);
    check("div1", 64'(cnt_lo), 64'd40);
    restart(1'b1, 4'd8); run(45);
    check("div9", 64'(cnt_lo), 64'd5);

    // Compare match, set-over-clear priority, masking and clear
    tcmp0 = 32'd5; tcmp1 = 32'd0; int_en = 1'b1;
    restart(1'b0, 4'd0);
    run_to(64'd5);
    int_st_clr = 1'b1;
    cyc();
    check("cmp_set", 64'(int_st), 64'd1);
    check("cmp_int", 64'(tim_int), 64'd1);
    int_st_clr = 1'b0; int_en = 1'b0;
    cyc();
    check("mask_int", 64'(tim_int), 64'd0);
    check("mask_st", 64'(int_st), 64'd1);
    int_en = 1'b1; int_st_clr = 1'b1;
    cyc();
    check("cmp_clr", 64'(int_st), 64'd0);
    int_st_clr = 1'b0;

    // 32-bit carry, then 64-bit wrap with match on all-ones
    tcmp0 = '1; tcmp1 = '1; timer_en = 1'b0;
    cyc();
    tdr0_wr = 1'b1; wr_data = 32'hFFFF_FFFF; cyc(); tdr0_wr = 1'b0;
    tdr1_wr = 1'b1; wr_data = 32'h0; cyc(); tdr1_wr = 1'b0;
    timer_en = 1'b1;
    run(2);
    check("carry_hi", 64'(cnt_hi), 64'd1);
    check("carry_lo", 64'(cnt_lo), 64'd0);
    timer_en = 1'b0; cyc();
    tdr0_wr = 1'b1; tdr1_wr = 1'b1; wr_data = 32'hFFFF_FFFF; cyc();
    tdr0_wr = 1'b0; tdr1_wr = 1'b0;
    check("ones_st0", 64'(int_st), 64'd0);
    timer_en = 1'b1; cyc();
    check("ones_st1", 64'(int_st), 64'd1);
    cyc();
    check("wrap_lo", 64'(cnt_lo), 64'd0);
    check("wrap_hi", 64'(cnt_hi), 64'd0);
    int_st_clr = 1'b1; cyc(); int_st_clr = 1'b0;

    // Debug halt
    dbg_mode = 1'b1;
    run(5);
    halt_req = 1'b1;
    cyc();
    check("halt_ack", 64'(halt_ack), 64'd1);
    hold = m_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("halt_frz", {cnt_hi, cnt_lo}, hold);
    end
    halt_req = 1'b0;
    cyc();
    check("halt_rel", 64'(halt_ack), 64'd0);
    cyc();
    check("halt_res", {cnt_hi, cnt_lo}, hold + 64'd1);
    dbg_mode = 1'b0; halt_req = 1'b1;
    run(3);
    check("nodbg", 64'(halt_ack), 64'd0);
    halt_req = 1'b0;

    // Disable clears count but keeps status; write wins over the clear
    tcmp0 = 32'd15; tcmp1 = 32'd0;
    run_to(64'd20);
    timer_en = 1'b0; cyc();
    check("dis_cnt", {cnt_hi, cnt_lo}, 64'd0);
    check("dis_st", 64'(int_st), 64'd1);
    timer_en = 1'b1; run(6);
    timer_en = 1'b0; tdr0_wr = 1'b1; wr_data = 32'd7; cyc();
    tdr0_wr = 1'b0;
    check("dis_wr", 64'(cnt_lo), 64'd7);

    // Reset while halted
    timer_en = 1'b1; dbg_mode = 1'b1; run(3);
    halt_req = 1'b1; run(2);
    check("pre_rst_ack", 64'(halt_ack), 64'd1);
    rst = 1'b1; cyc();
    check("rst_h_ack", 64'(halt_ack), 64'd0);
    check("rst_h_cnt", {cnt_hi, cnt_lo}, 64'd0);
    check("rst_h_st", 64'(int_st), 64'd0);
    rst = 1'b0; halt_req = 1'b0; dbg_mode = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) timer_en = !timer_en;
      if (!timer_en && $urandom_range(0, 3) == 0) begin
        div_en  = 1'($urandom_range(0, 1));
        div_val = 4'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 15) == 0) halt_req = !halt_req;
      if ($urandom_range(0, 31) == 0) dbg_mode = !dbg_mode;
      tdr0_wr    = ($urandom_range(0, 39) == 0);
      tdr1_wr    = ($urandom_range(0, 39) == 0);
      wr_data    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      int_st_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) int_en = !int_en;
      if ($urandom_range(0, 63) == 0) {tcmp1, tcmp0} = m_cnt + 64'($urandom_range(0, 5));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
